occupancy_sensor_conditioner: RTL
=================================

Name: occupancy_sensor_conditioner

Overview:
- Front-end stage for the room occupancy counter.
- Takes the raw, asynchronous beam-break outputs of the entrance and exit corridor sensors.
- Synchronises and debounces each sensor independently, then emits exactly one single-cycle pulse per qualified person-passage.
- Its outputs drive the counter's a (entry) and b (exit) inputs directly.

Parameters:
- DEBOUNCE_CYCLES, 16, consecutive synchronised samples needed to qualify a level change; legal range 2..65535.
- STUCK_CYCLES, 1000000, cycles a qualified-active sensor may stay active before being flagged stuck; used only with the optional feature.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous active-high reset.
- sens_in_raw  input  1  raw entrance sensor; 1 = beam broken; asynchronous to clk.
- sens_out_raw  input  1  raw exit sensor; 1 = beam broken; asynchronous to clk.
- enter_pulse  output  1  one-cycle pulse per qualified entrance event; feeds counter input a.
- exit_pulse  output  1  one-cycle pulse per qualified exit event; feeds counter input b.
- enter_level  output  1  debounced entrance sensor level.
- exit_level  output  1  debounced exit sensor level.
- stuck  output  2  bit0 = entrance stuck, bit1 = exit stuck; constant 0 without the optional feature.

Behaviour:
- Reset: while rst is high, all of the following are held at 0:
  - synchroniser flops, FSM states (IDLE), debounce counters, stuck counters;
  - enter_pulse, exit_pulse, enter_level, exit_level, stuck.
- Reset asserted mid-operation aborts immediately. Any pulse in progress is cut. No pulse is generated on release, even if raw is already high: it must qualify from IDLE.
- Each channel has a 2-flop synchroniser producing s; the FSM samples s only.
- Per-channel FSM states: IDLE, QUAL_ON, ACTIVE, QUAL_OFF. Debounce counter width is $clog2(DEBOUNCE_CYCLES+1).
- IDLE:
  - s=1 -> QUAL_ON, cnt=1.
  - otherwise stay.
- QUAL_ON:
  - s=0 -> IDLE, cnt=0 (glitch rejected, no pulse).
  - s=1 and cnt==DEBOUNCE_CYCLES-1 -> ACTIVE; the pulse register is set on this same edge.
  - s=1 otherwise -> cnt+1.
- ACTIVE:
  - level=1.
  - s=0 -> QUAL_OFF, cnt=1.
  - otherwise stay.
- QUAL_OFF:
  - s=1 -> ACTIVE, cnt=0 (dropout rejected, no new pulse).
  - s=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE.
  - s=0 otherwise -> cnt+1.
- Outputs are registered:
  - level = 1 in ACTIVE and QUAL_OFF.
  - The pulse is high for exactly one cycle, on the cycle following the IDLE/QUAL_ON -> ACTIVE edge.
- Latency: count the first edge that samples raw=1 as edge 1. The pulse and level rise after edge DEBOUNCE_CYCLES+2. Falling level has the same latency.
- Channels are fully independent. enter_pulse and exit_pulse may assert in the same cycle; the downstream counter treats that as no change, and this block does not arbitrate.
- Maximum pulse rate per channel: one per 2*DEBOUNCE_CYCLES cycles.
- Counters saturate and never wrap.

Optional Feature:
- Macro: OCC_SENSOR_STUCK_DET_EN.
- With the macro defined:
  - Each channel has a saturating stuck counter. It increments every cycle in ACTIVE and clears on entering IDLE. It is not cleared in QUAL_OFF, so rejected dropouts still count.
  - stuck[n] is set when the counter reaches STUCK_CYCLES.
  - stuck[n] is sticky until the channel returns to IDLE or rst is asserted.
  - While stuck[n]=1 no further pulses are produced on that channel.
- Without the macro: no stuck counters exist, and stuck is tied to 2'b00.

Decomposition:
- Package occ_sensor_pkg holds:
  - the state enum (IDLE, QUAL_ON, ACTIVE, QUAL_OFF);
  - channel index constants CH_ENTER=0 and CH_EXIT=1;
  - default-width localparam helpers.
- Sub-module occ_sensor_channel contains the synchroniser, FSM, debounce counter and optional stuck counter. The top instantiates it twice.

Test Plan (DEBOUNCE_CYCLES=4 unless stated):
- Clean entry: sens_in_raw 0->1 held for 20 cycles -> enter_pulse high for exactly one cycle, after edge 6; enter_level=1 until 6 edges after raw falls; exit_pulse stays 0.
- Glitch rejection: sens_out_raw high for 3 cycles, then low -> no exit_pulse; exit_level stays 0; FSM back in IDLE.
- Dropout rejection: sens_in_raw held high, with a 2-cycle low dip mid-hold -> exactly one enter_pulse total; enter_level never drops.
- Simultaneous events: both raws rise on the same edge -> enter_pulse and exit_pulse high in the same cycle, after edge 6.
- Reset mid-qualification: raw high, rst pulsed at cycle 3, raw kept high -> all outputs 0 during reset; a single pulse after edge 6 counted from the first post-reset edge.
- Stuck (macro defined, STUCK_CYCLES=50): raw held high for 100 cycles -> one pulse; stuck[0]=1 from ACTIVE cycle 50; stuck[0] clears once the channel returns to IDLE.

Source files
------------

// File: rtl/occ_sensor_pkg.sv
// Shared types and constants for the occupancy sensor front end.
package occ_sensor_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    QUAL_ON  = 2'd1,
    ACTIVE   = 2'd2,
    QUAL_OFF = 2'd3
  } state_t;

  localparam int unsigned CH_ENTER = 0;
  localparam int unsigned CH_EXIT  = 1;
  localparam int unsigned NUM_CH   = 2;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 16;
  localparam int unsigned DEF_STUCK_CYCLES    = 1000000;

  // Bits needed to hold values 0..max_count inclusive.
  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count < 1) ? 1 : $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/occ_sensor_channel.sv
// One sensor channel: 2-flop synchroniser, debounce FSM, registered pulse/level.
// Stuck detection is built only when OCC_SENSOR_STUCK_DET_EN is defined.
module occ_sensor_channel
  import occ_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic pulse,
  output logic level,
  output logic stuck
);

  localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = '1;

  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 65535 || STUCK_CYCLES < 1) begin : g_bad_param
    $error("occ_sensor_channel: illegal DEBOUNCE_CYCLES or STUCK_CYCLES");
  end

  logic          sync1;
  logic          s;
  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          pulse_nx, level_nx;
  logic          stuck_q;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_nx = QUAL_ON;
          cnt_nx   = CW'(1);
        end
      end
      QUAL_ON: begin
        if (!s) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CW'(1);
        end
      end
      ACTIVE: begin
        if (!s) begin
          state_nx = QUAL_OFF;
          cnt_nx   = CW'(1);
        end
      end
      QUAL_OFF: begin
        if (s) begin
          state_nx = ACTIVE;
          cnt_nx   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt != CNT_MAX) begin
          cnt_nx = cnt + CW'(1);
        end
      end
    endcase
  end

  // Pulse only on qualification from the inactive side; a rejected dropout re-enters ACTIVE silently.
  assign pulse_nx = (state == IDLE || state == QUAL_ON) && (state_nx == ACTIVE) && !stuck_q;
  assign level_nx = (state_nx == ACTIVE) || (state_nx == QUAL_OFF);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      sync1 <= raw;
      s     <= sync1;
      state <= state_nx;
      cnt   <= cnt_nx;
      pulse <= pulse_nx;
      level <= level_nx;
    end
  end

`ifdef OCC_SENSOR_STUCK_DET_EN
  localparam int unsigned SW = cnt_width(STUCK_CYCLES);
  localparam logic [SW-1:0] STK_MAX = SW'(STUCK_CYCLES);

  logic [SW-1:0] stk, stk_nx;
  logic          stuck_nx;

  // Time spent in QUAL_OFF is held, not cleared, so rejected dropouts still accumulate.
  always_comb begin
    stk_nx = stk;
    if (state == ACTIVE && stk != STK_MAX) stk_nx = stk + SW'(1);
    if (state_nx == IDLE) stk_nx = '0;
    stuck_nx = (state_nx != IDLE) && (stuck_q || (stk_nx == STK_MAX));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stk     <= '0;
      stuck_q <= 1'b0;
    end else begin
      stk     <= stk_nx;
      stuck_q <= stuck_nx;
    end
  end
`else
  assign stuck_q = 1'b0;
`endif

  assign stuck = stuck_q;

endmodule

// File: rtl/occupancy_sensor_conditioner.sv
// Entrance/exit sensor conditioner: two independent debounce channels feeding the occupancy counter.
// Optional stuck-sensor detection is enabled with OCC_SENSOR_STUCK_DET_EN.
module occupancy_sensor_conditioner
  import occ_sensor_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned STUCK_CYCLES    = DEF_STUCK_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sens_in_raw,
  input  logic              sens_out_raw,
  output logic              enter_pulse,
  output logic              exit_pulse,
  output logic              enter_level,
  output logic              exit_level,
  output logic [NUM_CH-1:0] stuck
);

  occ_sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_enter (
    .clk   (clk),
    .rst   (rst),
    .raw   (sens_in_raw),
    .pulse (enter_pulse),
    .level (enter_level),
    .stuck (stuck[CH_ENTER])
  );

  occ_sensor_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .STUCK_CYCLES    (STUCK_CYCLES)
  ) u_exit (
    .clk   (clk),
    .rst   (rst),
    .raw   (sens_out_raw),
    .pulse (exit_pulse),
    .level (exit_level),
    .stuck (stuck[CH_EXIT])
  );

endmodule
